pq_serial_loader: RTL
=====================

# pq_serial_loader

Upstream operand stage for the 5-bit gate-evaluation datapath. It receives a serial bitstream, assembles two WIDTH-bit operands P and Q, and presents them in parallel with a valid/ack handshake. The combinational evaluation block downstream consumes P and Q directly. P and Q change only when a complete frame has been accepted, so downstream outputs never see partial operands.

## Interface
Parameters:
- WIDTH, 5, bit width of each operand P and Q.
- MSB_FIRST, 1, 1: first received bit becomes bit WIDTH-1; 0: first received bit becomes bit 0.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begin a frame; sampled only in IDLE.
- sdi  input  1  serial data bit.
- sdi_valid  input  1  sdi is valid this cycle; low stalls the shift.
- ack  input  1  downstream has consumed P/Q; sampled only in HOLD.
- P  output  WIDTH  operand P, registered.
- Q  output  WIDTH  operand Q, registered.
- pq_valid  output  1  P/Q hold a new, unacknowledged frame.
- busy  output  1  high in every state except IDLE.
- par_err  output  1  one-cycle parity-failure pulse (see Configuration).

## Operation
- **States:** IDLE, LOAD_P, LOAD_Q, PAR (only when the macro is defined), HOLD. The bit counter runs from 0 to WIDTH-1.
- **IDLE:** start=1 moves to LOAD_P and clears the counter. sdi_valid is ignored in IDLE.
- **LOAD_P:** each cycle with sdi_valid=1 shifts sdi into the P shadow register and increments the counter. After the WIDTH-th bit: clear the counter and go to LOAD_Q. sdi_valid=0 holds state; there is no timeout.
- **LOAD_Q:** same behaviour into the Q shadow register. After the WIDTH-th bit, go to PAR if the macro is defined, otherwise to HOLD.
- **Entering HOLD:** P and Q load from their shadow registers in the same edge, and pq_valid is set.
- **P/Q stability:** P and Q are stable at all other times and keep their last frame's values through IDLE and the next load.
- **HOLD:** pq_valid stays 1 until ack=1. On ack, go to IDLE at the next edge with pq_valid=0.
- **start outside IDLE:** ignored, including a start in the same cycle as ack. start must be re-asserted in IDLE.
- **ack outside HOLD:** ignored.
- **Reset:** P=0, Q=0, pq_valid=0, busy=0, par_err=0, state=IDLE, counter=0, shadow registers=0. Reset mid-frame discards all partial data. rst has priority over every other input.

## Timing
- The start edge is cycle 0. With sdi_valid held high, P bits are accepted at edges 1..WIDTH and Q bits at edges WIDTH+1..2·WIDTH.
- Without the macro, pq_valid=1 after edge 2·WIDTH+1 (11 cycles for WIDTH=5). With the macro, the parity bit is accepted at edge 2·WIDTH+1 and pq_valid=1 after edge 2·WIDTH+2.
- Each stall cycle (sdi_valid=0) adds exactly one cycle.
- ack to pq_valid=0 and busy=0: 1 cycle.
- Minimum frame-to-frame spacing: ack edge, then start in IDLE on the next cycle.

## Configuration
- **Macro PQ_LOADER_PARITY_EN defined:**
  - After Q, one extra serial bit is accepted in PAR (stalls on sdi_valid=0 like the load states).
  - Parity is odd: popcount(P,Q,parity bit) must be odd.
  - Pass: go to HOLD as normal.
  - Fail: par_err=1 for exactly one cycle, return to IDLE, leave P/Q unchanged, keep pq_valid=0.
- **Macro undefined:**
  - No PAR state.
  - par_err is tied to 0.
  - The frame is 2·WIDTH bits.

## Structure
- **Shared header pq_loader_defs.vh:**
  - state encodings (IDLE=0, LOAD_P=1, LOAD_Q=2, PAR=3, HOLD=4; 3-bit);
  - default WIDTH.
- **Sub-module serial_shifter:** WIDTH-bit shift register with shift enable, clear, and MSB_FIRST parameter. It is instantiated twice (P, Q shadows).
- **Top level:** FSM, counter, output registers, and parity accumulator.

## Test plan
1. **Basic frame:** after reset, start, then continuous stream 1,0,1,1,0 then 0,1,1,0,0 (MSB_FIRST=1, no macro) -> P=22, Q=12, pq_valid=1 after edge 11, busy=1 until ack.
2. **Stalled stream:** same stream with sdi_valid low every other cycle -> pq_valid after edge 21, identical P/Q. P/Q keep previous values (0 after reset) throughout the load.
3. **Backpressure:** ack withheld 10 cycles with start pulsed during HOLD -> pq_valid stays 1, P/Q unchanged, start ignored. ack=1 -> pq_valid=0 and busy=0 next cycle.
4. **Reset mid-frame:** rst asserted after 3 Q bits -> all outputs 0 next cycle. The next full frame 0,0,0,1,1 / 1,1,1,1,1 yields P=3, Q=31.
5. **LSB-first order:** MSB_FIRST=0, stream 1,0,0,0,0 then 0,0,0,0,1 -> P=1, Q=16.
6. **Parity (macro defined):**
   - P=22, Q=12 (five ones) with parity bit 0 -> pq_valid after edge 12.
   - Same frame with parity bit 1 -> par_err pulse at edge 11 for one cycle, no pq_valid, P/Q unchanged.

Source files
------------

// File: rtl/pq_serial_loader_pkg.sv
// pq_serial_loader shared definitions: FSM state encoding,
// default operand width and a counter-width helper.
package pq_serial_loader_pkg;

    localparam int WIDTH_DEF = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_P = 3'd1,
        LOAD_Q = 3'd2,
        PAR    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/pq_serial_loader_if.sv
// Handshake/bus bundle between the serial source, the loader and
// the downstream evaluator. master drives the stream and ack,
// slave (the loader) drives P, Q, pq_valid, busy and par_err.
interface pq_serial_loader_if
    import pq_serial_loader_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             start;
    logic             sdi;
    logic             sdi_valid;
    logic             ack;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] Q;
    logic             pq_valid;
    logic             busy;
    logic             par_err;

    modport master (
        output start, sdi, sdi_valid, ack,
        input  P, Q, pq_valid, busy, par_err
    );

    modport slave (
        input  start, sdi, sdi_valid, ack,
        output P, Q, pq_valid, busy, par_err
    );

endinterface

// File: rtl/pq_serial_loader_serial_shifter.sv
// serial_shifter: WIDTH-bit shadow shift register for one operand.
// Ports: clk, rst (sync, active-high), clr, en, din -> q.
module serial_shifter #(
    parameter int WIDTH     = 5,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            // MSB-first shifts left so the first bit lands in WIDTH-1;
            // LSB-first shifts right so the first bit lands in bit 0.
            if (MSB_FIRST) begin
                q <= {q[WIDTH-2:0], din};
            end else begin
                q <= {din, q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/pq_serial_loader.sv
// pq_serial_loader: assembles serial P/Q operands and presents them
// in parallel with a valid/ack handshake.
// Ports: clk, rst (sync, active-high), bus (pq_serial_loader_if.slave):
//   start, sdi, sdi_valid, ack in; P, Q, pq_valid, busy, par_err out.
// Optional macro PQ_LOADER_PARITY_EN adds a trailing odd-parity bit.
module pq_serial_loader
    import pq_serial_loader_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    pq_serial_loader_if.slave    bus
);

    localparam int CW = cnt_bits(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic             pq_valid_q;
    logic             busy_q;
    logic             last;
    logic             clr;
    logic             shift_p;
    logic             shift_q;

    assign last    = (cnt == LAST);
    assign clr     = (state == IDLE) && bus.start;
    assign shift_p = (state == LOAD_P) && bus.sdi_valid;
    assign shift_q = (state == LOAD_Q) && bus.sdi_valid;

    serial_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_p_sh (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (shift_p),
        .din (bus.sdi),
        .q   (p_sh)
    );

    serial_shifter #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_q_sh (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (shift_q),
        .din (bus.sdi),
        .q   (q_sh)
    );

`ifdef PQ_LOADER_PARITY_EN
    logic par_acc;
    logic par_err_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            p_q        <= '0;
            q_q        <= '0;
            pq_valid_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef PQ_LOADER_PARITY_EN
            par_acc    <= 1'b0;
            par_err_q  <= 1'b0;
`endif
        end else begin
`ifdef PQ_LOADER_PARITY_EN
            par_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= LOAD_P;
                        cnt    <= '0;
                        busy_q <= 1'b1;
`ifdef PQ_LOADER_PARITY_EN
                        par_acc <= 1'b0;
`endif
                    end
                end
                LOAD_P: begin
                    if (bus.sdi_valid) begin
`ifdef PQ_LOADER_PARITY_EN
                        par_acc <= par_acc ^ bus.sdi;
`endif
                        if (last) begin
                            cnt   <= '0;
                            state <= LOAD_Q;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                LOAD_Q: begin
                    if (bus.sdi_valid) begin
`ifdef PQ_LOADER_PARITY_EN
                        par_acc <= par_acc ^ bus.sdi;
`endif
                        if (last) begin
                            cnt <= '0;
`ifdef PQ_LOADER_PARITY_EN
                            state <= PAR;
`else
                            state <= HOLD;
`endif
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
`ifdef PQ_LOADER_PARITY_EN
                PAR: begin
                    if (bus.sdi_valid) begin
                        // Odd parity: running XOR plus this bit must be 1.
                        if (par_acc ^ bus.sdi) begin
                            state <= HOLD;
                        end else begin
                            state     <= IDLE;
                            busy_q    <= 1'b0;
                            par_err_q <= 1'b1;
                        end
                    end
                end
`endif
                HOLD: begin
                    // First HOLD cycle publishes the shadows (the last
                    // serial bit is only in the shadow after the entry
                    // edge); ack is honoured once pq_valid is up.
                    if (!pq_valid_q) begin
                        p_q        <= p_sh;
                        q_q        <= q_sh;
                        pq_valid_q <= 1'b1;
                    end else if (bus.ack) begin
                        pq_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.P        = p_q;
    assign bus.Q        = q_q;
    assign bus.pq_valid = pq_valid_q;
    assign bus.busy     = busy_q;
`ifdef PQ_LOADER_PARITY_EN
    assign bus.par_err  = par_err_q;
`else
    assign bus.par_err  = 1'b0;
`endif

endmodule
